// File: rtl/iq_phase_detector.sv
// Quadrature phase detector: multiplies the ADC stream by the DDS I/Q references,
// averages each product over 2^DECIM_LOG2 samples and tracks loop lock.
module iq_phase_detector #(
    parameter int unsigned DECIM_LOG2   = 8,
    parameter int          LOCK_THRESH  = 1024,
    parameter int unsigned LOCK_WINDOWS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  adc_data,
    input  logic        adc_valid,
    input  logic [7:0]  dac_data,
    input  logic [7:0]  q_dac_data,
    output logic [15:0] phase_error,
    output logic [15:0] i_avg,
    output logic [15:0] q_avg,
    output logic        error_valid,
    output logic        locked
);

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned PROD_W   = 16;
    localparam int unsigned ABS_W    = PROD_W + 1;
    localparam int unsigned ACC_W    = PROD_W + DECIM_LOG2;
    localparam int unsigned CNT_W    = DECIM_LOG2;
    localparam int unsigned LOCK_W   = $clog2(LOCK_WINDOWS + 1);

    localparam logic [LOCK_W-1:0]       LOCK_FULL = LOCK_W'(LOCK_WINDOWS);
    localparam logic signed [ABS_W-1:0] THRESH    = ABS_W'(LOCK_THRESH);

    // Offset binary to two's complement: flip the MSB.
    function automatic logic signed [SAMPLE_W-1:0] ob_to_sc(input logic [SAMPLE_W-1:0] x);
        return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
    endfunction

    // Stage 1 registers
    logic                       s1_valid_q, s1_valid_d;
    logic signed [SAMPLE_W-1:0] s1_adc_q, s1_adc_d;
    logic signed [SAMPLE_W-1:0] s1_ref_i_q, s1_ref_i_d;
    logic signed [SAMPLE_W-1:0] s1_ref_q_q, s1_ref_q_d;

    // Stage 2 registers
    logic                       s2_valid_q, s2_valid_d;
    logic signed [PROD_W-1:0]   prod_i_q, prod_i_d;
    logic signed [PROD_W-1:0]   prod_q_q, prod_q_d;

    // Stage 3 accumulators and window counter
    logic signed [ACC_W-1:0]    acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0]    acc_q_q, acc_q_d;
    logic [CNT_W-1:0]           win_cnt_q, win_cnt_d;

    // Output and lock registers
    logic signed [PROD_W-1:0]   i_avg_q, i_avg_d;
    logic signed [PROD_W-1:0]   q_avg_q, q_avg_d;
    logic signed [PROD_W-1:0]   phase_error_q, phase_error_d;
    logic                       error_valid_q, error_valid_d;
    logic                       locked_q, locked_d;
    logic [LOCK_W-1:0]          lock_cnt_q, lock_cnt_d;

    // Combinational intermediates
    logic signed [PROD_W-1:0]   adc_ext, ref_i_ext, ref_q_ext;
    logic signed [ACC_W-1:0]    acc_sum_i, acc_sum_q;
    logic signed [PROD_W-1:0]   avg_i_new, avg_q_new;
    logic signed [ABS_W-1:0]    q_wide, q_abs;
    logic                       window_last;
    logic                       window_ok;

    // Sign-extend stage-1 operands so the product is formed at full width.
    always_comb begin
        adc_ext   = PROD_W'(s1_adc_q);
        ref_i_ext = PROD_W'(s1_ref_i_q);
        ref_q_ext = PROD_W'(s1_ref_q_q);
    end

    // Window sums including the product being accumulated this cycle.
    always_comb begin
        acc_sum_i   = acc_i_q + ACC_W'(prod_i_q);
        acc_sum_q   = acc_q_q + ACC_W'(prod_q_q);
        avg_i_new   = PROD_W'(acc_sum_i >>> DECIM_LOG2);
        avg_q_new   = PROD_W'(acc_sum_q >>> DECIM_LOG2);
        window_last = s2_valid_q && (win_cnt_q == '1);
    end

    // Lock qualification of the averages about to be presented.
    always_comb begin
        q_wide    = ABS_W'(avg_q_new);
        q_abs     = (q_wide < 0) ? -q_wide : q_wide;
        window_ok = (q_abs < THRESH) && (avg_i_new > 0);
    end

    // Next-state logic for all pipeline, window and lock state.
    always_comb begin
        s1_valid_d    = 1'b0;
        s1_adc_d      = s1_adc_q;
        s1_ref_i_d    = s1_ref_i_q;
        s1_ref_q_d    = s1_ref_q_q;
        s2_valid_d    = 1'b0;
        prod_i_d      = prod_i_q;
        prod_q_d      = prod_q_q;
        acc_i_d       = acc_i_q;
        acc_q_d       = acc_q_q;
        win_cnt_d     = win_cnt_q;
        i_avg_d       = i_avg_q;
        q_avg_d       = q_avg_q;
        phase_error_d = phase_error_q;
        error_valid_d = 1'b0;
        locked_d      = locked_q;
        lock_cnt_d    = lock_cnt_q;

        if (!enable) begin
            acc_i_d    = '0;
            acc_q_d    = '0;
            win_cnt_d  = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            s1_valid_d = adc_valid;
            if (adc_valid) begin
                s1_adc_d   = ob_to_sc(adc_data);
                s1_ref_i_d = ob_to_sc(dac_data);
                s1_ref_q_d = ob_to_sc(q_dac_data);
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                prod_i_d = adc_ext * ref_i_ext;
                prod_q_d = adc_ext * ref_q_ext;
            end

            if (window_last) begin
                acc_i_d       = '0;
                acc_q_d       = '0;
                win_cnt_d     = '0;
                i_avg_d       = avg_i_new;
                q_avg_d       = avg_q_new;
                phase_error_d = avg_q_new;
                error_valid_d = 1'b1;
                if (!window_ok) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q != LOCK_FULL) begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
                locked_d = (lock_cnt_d == LOCK_FULL);
            end else if (s2_valid_q) begin
                acc_i_d   = acc_sum_i;
                acc_q_d   = acc_sum_q;
                win_cnt_d = win_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s1_adc_q      <= '0;
            s1_ref_i_q    <= '0;
            s1_ref_q_q    <= '0;
            s2_valid_q    <= 1'b0;
            prod_i_q      <= '0;
            prod_q_q      <= '0;
            acc_i_q       <= '0;
            acc_q_q       <= '0;
            win_cnt_q     <= '0;
            i_avg_q       <= '0;
            q_avg_q       <= '0;
            phase_error_q <= '0;
            error_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            lock_cnt_q    <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_adc_q      <= s1_adc_d;
            s1_ref_i_q    <= s1_ref_i_d;
            s1_ref_q_q    <= s1_ref_q_d;
            s2_valid_q    <= s2_valid_d;
            prod_i_q      <= prod_i_d;
            prod_q_q      <= prod_q_d;
            acc_i_q       <= acc_i_d;
            acc_q_q       <= acc_q_d;
            win_cnt_q     <= win_cnt_d;
            i_avg_q       <= i_avg_d;
            q_avg_q       <= q_avg_d;
            phase_error_q <= phase_error_d;
            error_valid_q <= error_valid_d;
            locked_q      <= locked_d;
            lock_cnt_q    <= lock_cnt_d;
        end
    end

    assign phase_error = phase_error_q;
    assign i_avg       = i_avg_q;
    assign q_avg       = q_avg_q;
    assign error_valid = error_valid_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_iq_phase_detector.sv
// Scoreboard bench for iq_phase_detector: a sample-level reference model predicts each
// window result and its edge; a negedge monitor pops and compares on every error_valid.
module tb_iq_phase_detector;

    localparam int LOG2   = 8;
    localparam int N      = 1 << LOG2;
    localparam int THRESH = 1024;
    localparam int LWIN   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  adc_data = 8'd128;
    logic        adc_valid = 1'b0;
    logic [7:0]  dac_data = 8'd128;
    logic [7:0]  q_dac_data = 8'd128;
    logic [15:0] phase_error, i_avg, q_avg;
    logic        error_valid, locked;

    iq_phase_detector #(.DECIM_LOG2(LOG2), .LOCK_THRESH(THRESH), .LOCK_WINDOWS(LWIN)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .dac_data(dac_data), .q_dac_data(q_dac_data),
        .phase_error(phase_error), .i_avg(i_avg), .q_avg(q_avg),
        .error_valid(error_valid), .locked(locked)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int pi; int pq; int due; } pend_t;
    typedef struct { int i; int q; int lk; int cyc; } exp_t;

    pend_t pend[$];
    exp_t  exp_q[$];
    int    cyc = 0;
    int    sum_i = 0, sum_q = 0, cnt = 0, lock_cnt = 0;
    int    cur_i = 0, cur_q = 0, exp_locked = 0;

    function automatic int floor_div(input int s);
        int r;
        r = s / N;
        if ((s % N) != 0 && s < 0) r = r - 1;
        return r;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk) begin
        pend_t p;
        exp_t  e;
        cyc++;
        if (!reset) begin
            pend.delete();
            sum_i = 0; sum_q = 0; cnt = 0; lock_cnt = 0;
            cur_i = 0; cur_q = 0; exp_locked = 0;
        end else if (!enable) begin
            pend.delete();
            sum_i = 0; sum_q = 0; cnt = 0; lock_cnt = 0;
            exp_locked = 0;
        end else begin
            while (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                sum_i += p.pi;
                sum_q += p.pq;
                cnt++;
                if (cnt == N) begin
                    cur_i = floor_div(sum_i);
                    cur_q = floor_div(sum_q);
                    if (iabs(cur_q) < THRESH && cur_i > 0)
                        lock_cnt = (lock_cnt < LWIN) ? lock_cnt + 1 : LWIN;
                    else
                        lock_cnt = 0;
                    exp_locked = (lock_cnt == LWIN) ? 1 : 0;
                    e.i = cur_i; e.q = cur_q; e.lk = exp_locked; e.cyc = cyc;
                    exp_q.push_back(e);
                    sum_i = 0; sum_q = 0; cnt = 0;
                end
            end
            if (adc_valid) begin
                p.pi  = (int'(adc_data) - 128) * (int'(dac_data) - 128);
                p.pq  = (int'(adc_data) - 128) * (int'(q_dac_data) - 128);
                p.due = cyc + 2;
                pend.push_back(p);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (error_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_edge", cyc, e.cyc);
                    check("i_avg", int'($signed(i_avg)), e.i);
                    check("q_avg", int'($signed(q_avg)), e.q);
                    check("phase_error", int'($signed(phase_error)), e.q);
                    check("locked_pulse", int'(locked), e.lk);
                end
            end else begin
                check("missing_pulse", exp_q.size(), 0);
                check("hold_i_avg", int'($signed(i_avg)), cur_i);
                check("hold_q_avg", int'($signed(q_avg)), cur_q);
                check("hold_phase_error", int'($signed(phase_error)), cur_q);
                check("hold_locked", int'(locked), exp_locked);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rn, input logic en, input logic v,
                        input logic [7:0] a, input logic [7:0] d, input logic [7:0] q);
        @(negedge clk);
        reset = rn; enable = en; adc_valid = v;
        adc_data = a; dac_data = d; q_dac_data = q;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 8'd128, 8'd128, 8'd128);
    endtask

    function automatic logic [7:0] dds(input longint unsigned ph, input bit cosine);
        real ang;
        int  v;
        ang = 2.0 * 3.14159265358979 * real'(ph) / 4294967296.0;
        v = 128 + int'($rtoi((cosine ? $cos(ang) : $sin(ang)) * 127.0 + 128.5) - 128);
        return 8'(v);
    endfunction

    initial begin
        longint unsigned ph;
        logic [7:0] sv, cv, ra;
        int iv, qv;

        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 8'd128, 8'd128, 8'd128);
        mon_en = 1'b1;
        check("reset_i_avg", int'(i_avg), 0);
        check("reset_locked", int'(locked), 0);

        // in-phase DC with a one-cycle reset after 100 samples
        for (int k = 0; k < 100; k++) step(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd128);
        step(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd128);
        step(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd128);
        check("reset_mid_q_avg", int'(q_avg), 0);
        check("reset_mid_ev", int'(error_valid), 0);
        for (int k = 1; k < 4 * N; k++) step(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd128);
        idle(3);
        check("ip_i_avg", int'($signed(i_avg)), 16129);
        check("ip_phase_error", int'($signed(phase_error)), 0);
        check("ip_locked", int'(locked), 1);

        // quadrature DC drops lock
        for (int k = 0; k < N; k++) step(1'b1, 1'b1, 1'b1, 8'd0, 8'd128, 8'd255);
        idle(3);
        check("quad_phase_error", int'(phase_error), 16'hC080);
        check("quad_i_avg", int'($signed(i_avg)), 0);
        check("quad_locked", int'(locked), 0);

        // gapped valid, every third cycle
        for (int k = 0; k < 2 * N * 3; k++)
            step(1'b1, 1'b1, (k % 3) == 0, 8'd255, 8'd255, 8'd128);
        idle(3);
        check("gap_i_avg", int'($signed(i_avg)), 16129);

        // enable drop mid-window and on the completing edge
        step(1'b1, 1'b0, 1'b0, 8'd128, 8'd128, 8'd128);
        for (int k = 0; k < 100; k++) step(1'b1, 1'b1, 1'b1, 8'd0, 8'd128, 8'd255);
        step(1'b1, 1'b0, 1'b1, 8'd0, 8'd128, 8'd255);
        for (int k = 0; k < N; k++) step(1'b1, 1'b1, 1'b1, 8'd0, 8'd128, 8'd255);
        step(1'b1, 1'b1, 1'b0, 8'd128, 8'd128, 8'd128);
        step(1'b1, 1'b0, 1'b0, 8'd128, 8'd128, 8'd128);
        step(1'b1, 1'b0, 1'b0, 8'd128, 8'd128, 8'd128);
        check("drop_held_i_avg", int'($signed(i_avg)), 16129);
        check("drop_ev", int'(error_valid), 0);
        for (int k = 0; k < N; k++) step(1'b1, 1'b1, 1'b1, 8'd0, 8'd128, 8'd255);
        idle(3);
        check("reen_phase_error", int'($signed(phase_error)), -16256);

        // sine references, adc tied to I then to Q
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b1, 1'b0, 1'b0, 8'd128, 8'd128, 8'd128);
            ph = 0;
            for (int k = 0; k < N; k++) begin
                sv = dds(ph, 1'b0);
                cv = dds(ph, 1'b1);
                step(1'b1, 1'b1, 1'b1, (pass == 0) ? sv : cv, sv, cv);
                ph = (ph + 64'h0080_0000) & 64'hFFFF_FFFF;
            end
            idle(3);
            iv = int'($signed(i_avg));
            qv = int'($signed(q_avg));
            if (pass == 0) begin
                check("sine_i_near_8000", int'(iabs(iv - 8000) <= 160), 1);
                check("sine_q_near_0", int'(iabs(qv) <= 160), 1);
            end else begin
                check("sine_q_near_8000", int'(iabs(qv - 8000) <= 160), 1);
                check("sine_i_near_0", int'(iabs(iv) <= 160), 1);
            end
        end

        // random traffic with occasional enable drops
        for (int k = 0; k < 2000; k++)
            step(1'b1, $urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));
        // random near-lock traffic
        for (int k = 0; k < 2500; k++) begin
            ra = 8'($urandom_range(0, 255));
            step(1'b1, $urandom_range(0, 999) != 0, $urandom_range(0, 3) != 0,
                 ra, ra, 8'($urandom_range(125, 131)));
        end
        idle(5);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iq_phase_detector.md
# iq_phase_detector

Quadrature phase detector closing the PLL loop between the DDS and the frequency sweeper. It samples the ADC input against the DDS in-phase and quadrature reference outputs and multiplies each pair. It averages the products over a fixed window and delivers a signed 16-bit `phase_error` to the sweeper's `phase_error` input, together with a lock indicator. It runs on the 50 MHz system clock and is enabled by the sweeper's `pll_enable`.

## Interface
- `DECIM_LOG2`, default 8: log2 of the averaging window; N = 2^DECIM_LOG2 accepted samples per window, legal range 1..12.
- `LOCK_THRESH`, default 1024: lock qualifies when |q_avg| < LOCK_THRESH and i_avg > 0.
- `LOCK_WINDOWS`, default 4: consecutive qualifying windows required to assert `locked`.
- `clk`  in  1  system clock, 50 MHz. All logic is on the rising edge.
- `reset`  in  1  reset; synchronous, active-low.
- `enable`  in  1  detector enable (from sweeper `pll_enable`).
- `adc_data`  in  8  received signal, offset binary (128 = zero).
- `adc_valid`  in  1  `adc_data` is a new sample this cycle.
- `dac_data`  in  8  DDS in-phase reference, offset binary.
- `q_dac_data`  in  8  DDS quadrature reference, offset binary.
- `phase_error`  out  16  signed phase error (= q_avg).
- `i_avg`  out  16  signed window-averaged I product.
- `q_avg`  out  16  signed window-averaged Q product.
- `error_valid`  out  1  one-cycle pulse when new averages are presented.
- `locked`  out  1  lock indicator.

## Operation
- Stage 1, on an `adc_valid` edge: convert all three inputs to two's complement by inverting the MSB, giving a range of -128..+127. Register them together with a valid bit. The reference inputs are sampled on the same edge as `adc_data`.
- Stage 2: compute the signed 8x8 products p_i = adc·ref_i and p_q = adc·ref_q into 16-bit signed registers. The range is -16256..+16384, so no overflow is possible.
- Stage 3: accumulate p_i and p_q into (16+DECIM_LOG2)-bit signed accumulators and count samples with a DECIM_LOG2-bit window counter.
- On the edge that accumulates the Nth sample of a window:
  - i_avg and q_avg ← (acc + product) >>> DECIM_LOG2, an arithmetic shift that truncates toward -inf.
  - phase_error ← the new q_avg.
  - error_valid ← 1.
  - Accumulators and the counter clear to 0.
- Gaps in `adc_valid` stall the pipeline stages in place; bubbles carry no sample and are not counted.
- Lock counter, updated only on error_valid windows:
  - A window qualifies if |q_avg| < LOCK_THRESH and i_avg > 0.
  - A qualifying window increments the counter, saturating at LOCK_WINDOWS.
  - A non-qualifying window clears the counter to 0.
  - `locked` = (counter == LOCK_WINDOWS), registered. It updates on the same edge as the window outputs.
- `enable` low:
  - Pipeline valid bits, accumulators, the window counter and the lock counter clear to 0.
  - `locked` = 0 and `error_valid` = 0.
  - phase_error, i_avg and q_avg hold their last values.
  - When `enable` rises, a fresh window starts with the first subsequent `adc_valid`.
- Simultaneous window completion and `enable` falling: `enable` wins. No pulse is emitted and the outputs are not updated.

## Timing
- Reset (`reset` == 0 at an edge): every output is 0 (`phase_error`, `i_avg`, `q_avg`, `error_valid`, `locked`). All internal registers are also 0.
- Latency: a sample accepted at edge E reaches stage 2 at E+1 and is accumulated at E+2.
  - If that sample is the Nth of its window, `error_valid` is high during the cycle after E+2 and the new outputs are visible then.
- With `adc_valid` held high continuously, `error_valid` pulses every N cycles. The first pulse follows the edge N+1 cycles after the first accepted sample.
- `error_valid` is always a single-cycle pulse. The outputs are stable between pulses.
- Accumulator width (16+DECIM_LOG2) cannot overflow for any N in the legal range.

## Test plan
- Reset mid-window: apply `reset`=0 for 1 cycle after 100 samples, with `enable`=1 and `adc_valid`=1 throughout → all outputs 0. The next `error_valid` occurs exactly 256 accepted samples after reset release.
- In-phase DC: `adc_data`=255, `dac_data`=255, `q_dac_data`=128, N=256 → after 256 samples `i_avg`=16129 and `q_avg`=`phase_error`=0. `locked` rises at the 4th window.
- Quadrature DC: `adc_data`=0, `q_dac_data`=255, `dac_data`=128 → `phase_error`=0xC080 (-16256) and `i_avg`=0. `locked` stays 0; a prior lock drops on the first such window.
- Gapped valid: `adc_valid` high every 3rd cycle using the in-phase DC values → identical averages. `error_valid` follows the 256th accepted sample by exactly 2 edges.
- Enable drop: deassert `enable` mid-window and again on the completing edge → no `error_valid`, outputs held, `locked`=0. After re-enable, the first pulse comes after 256 new samples.
- Sine check: the DDS is driven with tuning word 0x00800000, with `adc_data` tied to `dac_data` then to `q_dac_data` → `q_avg` ≈ 0 with `i_avg` ≈ +8000 (within 2%), then `i_avg` ≈ 0 with `q_avg` ≈ +8000 (within 2%).
